music_sequencer: RTL



---
 rtl/music_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/music_sequencer.sv
// Song sequencer: walks a synchronous song ROM and drives the tone generator's
// half-period and enable, holding each note for beats x beat_cycles clocks.
module music_sequencer #(
  parameter int ADDR_WIDTH   = 10,
  parameter int PERIOD_WIDTH = 24,
  parameter int BEATS_WIDTH  = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                play,
  input  logic                                pause,
  input  logic                                stop,
  input  logic                                loop_en,
  input  logic [23:0]                         beat_cycles,
  output logic [ADDR_WIDTH-1:0]               rom_addr,
  input  logic [BEATS_WIDTH+PERIOD_WIDTH-1:0] rom_data,
  output logic [PERIOD_WIDTH-1:0]             tone_switch_period,
  output logic                                output_enable,
  output logic                                playing,
  output logic                                paused,
  output logic                                done
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, PAUSED} state_t;

  state_t                  state, next;
  logic [BEATS_WIDTH-1:0]  beat_cnt;
  logic [23:0]             cycle_cnt;
  logic [23:0]             reload;
  logic [BEATS_WIDTH-1:0]  rom_beats;
  logic [PERIOD_WIDTH-1:0] rom_period;
  logic                    end_marker;
  logic                    note_end;

  assign rom_beats  = rom_data[BEATS_WIDTH+PERIOD_WIDTH-1:PERIOD_WIDTH];
  assign rom_period = rom_data[PERIOD_WIDTH-1:0];
  assign end_marker = (rom_beats == '0);
  // beat_cycles of 0 behaves as 1: one PLAY cycle per beat
  assign reload     = (beat_cycles == '0) ? '0 : beat_cycles - 24'd1;
  assign note_end   = (cycle_cnt == '0) && (beat_cnt == BEATS_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (play) next = FETCH;
      FETCH:   next = LOAD;
      LOAD: begin
        if (!end_marker)  next = PLAY;
        else if (loop_en) next = FETCH;
        else              next = IDLE;
      end
      PLAY: begin
        if (pause)         next = PAUSED;
        else if (note_end) next = FETCH;
      end
      PAUSED:  if (play) next = PLAY;
      default: next = IDLE;
    endcase
    if (stop) next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr           <= '0;
      tone_switch_period <= '0;
      output_enable      <= 1'b0;
      playing            <= 1'b0;
      paused             <= 1'b0;
      done               <= 1'b0;
      beat_cnt           <= '0;
      cycle_cnt          <= '0;
    end else begin
      playing <= (next == FETCH) || (next == LOAD) || (next == PLAY);
      paused  <= (next == PAUSED);
      done    <= 1'b0;
      if (stop) begin
        rom_addr           <= '0;
        tone_switch_period <= '0;
        output_enable      <= 1'b0;
        beat_cnt           <= '0;
        cycle_cnt          <= '0;
      end else begin
        unique case (state)
          IDLE: if (play) rom_addr <= '0;
          LOAD: begin
            if (end_marker) begin
              rom_addr <= '0;
              if (!loop_en) begin
                done               <= 1'b1;
                output_enable      <= 1'b0;
                tone_switch_period <= '0;
              end
            end else begin
              tone_switch_period <= rom_period;
              output_enable      <= (rom_period != '0);
              beat_cnt           <= rom_beats;
              cycle_cnt          <= reload;
            end
          end
          PLAY: begin
            if (pause) begin
              output_enable <= 1'b0;
            end else if (cycle_cnt == '0) begin
              beat_cnt  <= beat_cnt - BEATS_WIDTH'(1);
              cycle_cnt <= reload;
              if (beat_cnt == BEATS_WIDTH'(1)) rom_addr <= rom_addr + ADDR_WIDTH'(1);
            end else begin
              cycle_cnt <= cycle_cnt - 24'd1;
            end
          end
          PAUSED: if (play) output_enable <= (tone_switch_period != '0);
          default: ;
        endcase
      end
    end
  end

endmodule
